// File: rtl/conv_pkg.sv
// Constants and state encoding shared between the convolution core and its result serializer.
package conv_pkg;

  localparam int unsigned DIM     = 3;
  localparam int unsigned RES_W   = 2;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned NELEM   = DIM * DIM;
  localparam int unsigned FRAME_W = NELEM * RES_W;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_e;

endpackage

// File: rtl/conv_frame_slot.sv
// One-frame holding register with a full flag; load captures a frame and sets full.
module conv_frame_slot #(
  parameter int unsigned WIDTH = conv_pkg::FRAME_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= din;
      end
      // A load in the same cycle as a clear keeps the slot occupied.
      if (load) begin
        full_q <= 1'b1;
      end else if (clear) begin
        full_q <= 1'b0;
      end
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/conv_result_serializer.sv
// Double-buffered serializer: streams a parallel DIM x DIM result frame one element per cycle
// with row/column/last tags, capturing the next frame while the current one drains.
module conv_result_serializer #(
  parameter int unsigned RES_W = conv_pkg::RES_W,
  parameter int unsigned DIM   = conv_pkg::DIM,
  parameter int unsigned IDX_W = conv_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic [DIM*DIM*RES_W-1:0] frame_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [RES_W-1:0]         pix_data,
  output logic [IDX_W-1:0]         pix_row,
  output logic [IDX_W-1:0]         pix_col,
  output logic                     pix_last,
  output logic                     busy
);

  import conv_pkg::*;

  localparam int unsigned NElem  = DIM * DIM;
  localparam int unsigned FrameW = NElem * RES_W;
  localparam int unsigned CntW   = $clog2(NElem);
  localparam logic [CntW-1:0]  LastCnt = CntW'(NElem - 1);
  localparam logic [IDX_W-1:0] LastCol = IDX_W'(DIM - 1);

  ser_state_e        state_q, state_d;
  logic [FrameW-1:0] act_q, act_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  col_q, col_d;

  logic              pend_load, pend_clear, pend_full;
  logic [FrameW-1:0] pend_data;
  logic              accept, xfer, last_xfer;

  conv_frame_slot #(
    .WIDTH(FrameW)
  ) u_pending (
    .clk  (clk),
    .rst  (rst),
    .load (pend_load),
    .clear(pend_clear),
    .din  (frame_data),
    .dout (pend_data),
    .full (pend_full)
  );

  assign frame_ready = ~pend_full;
  assign pix_valid   = (state_q == StSend);
  assign pix_data    = act_q[RES_W-1:0];
  assign pix_row     = row_q;
  assign pix_col     = col_q;
  assign pix_last    = pix_valid && (cnt_q == LastCnt);
  assign busy        = pix_valid | pend_full;

  assign accept    = frame_valid & frame_ready;
  assign xfer      = pix_valid & pix_ready;
  assign last_xfer = xfer && (cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_load  = 1'b0;
    pend_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          act_d   = frame_data;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (last_xfer) begin
          cnt_d = '0;
          row_d = '0;
          col_d = '0;
          // Refill from pending first; frame_ready is low whenever pending is full.
          if (pend_full) begin
            act_d      = pend_data;
            pend_clear = 1'b1;
          end else if (accept) begin
            act_d = frame_data;
          end else begin
            act_d   = '0;
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            act_d = act_q >> RES_W;
            cnt_d = cnt_q + 1'b1;
            if (col_q == LastCol) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          pend_load = accept;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      act_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed bench for conv_result_serializer: table-driven single frame plus multi-cycle sequences.
module tb_conv_result_serializer;

  import conv_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;
  logic               pix_valid;
  logic               pix_ready;
  logic [RES_W-1:0]   pix_data;
  logic [IDX_W-1:0]   pix_row;
  logic [IDX_W-1:0]   pix_col;
  logic               pix_last;
  logic               busy;

  conv_result_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_last   (pix_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef int elems_t [9];

  typedef struct {
    logic [1:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] pack(input elems_t e);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[k*RES_W +: RES_W] = RES_W'(e[k]);
    return f;
  endfunction

  // Checks that element k of frame e is presented with its tags.
  task automatic show(input string tag, input elems_t e, input int k);
    chk($sformatf("%s.e%0d valid", tag, k), 32'(pix_valid), 1);
    chk($sformatf("%s.e%0d data", tag, k), 32'(pix_data), e[k]);
    chk($sformatf("%s.e%0d row", tag, k), 32'(pix_row), k / 3);
    chk($sformatf("%s.e%0d col", tag, k), 32'(pix_col), k % 3);
    chk($sformatf("%s.e%0d last", tag, k), 32'(pix_last), (k == 8) ? 1 : 0);
  endtask

  task automatic drain(input string tag, input elems_t e);
    pix_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      show(tag, e, k);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(pix_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " frame_ready"}, 32'(frame_ready), 1);
  endtask

  vec_t   vecs [9];
  elems_t t1, e2, a3, b3, c4, d4, e5, f5, g5, h6, i6, j6, cur;
  int     got, cnt;
  bit     sent_j;

  initial begin
    rst         = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    pix_ready   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_idle("rst");
    chk("rst data", 32'(pix_data), 0);
    chk("rst row", 32'(pix_row), 0);
    chk("rst col", 32'(pix_col), 0);
    chk("rst last", 32'(pix_last), 0);
    rst = 1'b0;

    // Single frame against a hand-written table
    t1 = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    vecs[0] = '{2'd1, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{2'd2, 2'd0, 2'd1, 1'b0};
    vecs[2] = '{2'd3, 2'd0, 2'd2, 1'b0};
    vecs[3] = '{2'd0, 2'd1, 2'd0, 1'b0};
    vecs[4] = '{2'd1, 2'd1, 2'd1, 1'b0};
    vecs[5] = '{2'd2, 2'd1, 2'd2, 1'b0};
    vecs[6] = '{2'd3, 2'd2, 2'd0, 1'b0};
    vecs[7] = '{2'd0, 2'd2, 2'd1, 1'b0};
    vecs[8] = '{2'd1, 2'd2, 2'd2, 1'b1};
    frame_data  = pack(t1);
    frame_valid = 1'b1;
    pix_ready   = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1.v%0d valid", i), 32'(pix_valid), 1);
      chk($sformatf("t1.v%0d data", i), 32'(pix_data), 32'(vecs[i].data));
      chk($sformatf("t1.v%0d row", i), 32'(pix_row), 32'(vecs[i].row));
      chk($sformatf("t1.v%0d col", i), 32'(pix_col), 32'(vecs[i].col));
      chk($sformatf("t1.v%0d last", i), 32'(pix_last), 32'(vecs[i].last));
      @(negedge clk);
    end
    chk_idle("t1 end");

    // Backpressure: pix_ready pattern 1,0,0,1,0,0,...
    e2 = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
    frame_data  = pack(e2);
    frame_valid = 1'b1;
    pix_ready   = 1'b0;
    @(negedge clk);
    frame_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
      show("t2", e2, got);
      pix_ready = (cyc % 3 == 0);
      if (pix_ready) got++;
      @(negedge clk);
    end
    chk("t2 transfers", 32'(got), 9);
    chk_idle("t2 end");
    pix_ready = 1'b1;

    // Back-to-back frames: B waits in pending, no gap between A and B
    a3 = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    b3 = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    frame_data  = pack(a3);
    frame_valid = 1'b1;
    @(negedge clk);
    cnt = 0;
    for (int cyc = 0; cyc < 40 && cnt < 18; cyc++) begin
      if (cnt == 0) frame_data = pack(b3);
      if (cnt == 1) begin
        frame_valid = 1'b0;
        chk("t3 ready after B", 32'(frame_ready), 0);
      end
      if (cnt < 9) cur = a3;
      else cur = b3;
      show($sformatf("t3.%0d", cnt), cur, cnt % 9);
      if (cnt == 8) chk("t3 ready at A last", 32'(frame_ready), 0);
      if (cnt == 9) chk("t3 ready at B e0", 32'(frame_ready), 1);
      cnt++;
      @(negedge clk);
    end
    chk("t3 transfers", 32'(cnt), 18);
    chk_idle("t3 end");

    // New frame offered on the same edge as the last transfer, pending empty
    c4 = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    d4 = '{3, 3, 2, 2, 1, 1, 0, 0, 3};
    frame_data  = pack(c4);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      show("t4c", c4, k);
      if (k == 8) begin
        frame_data  = pack(d4);
        frame_valid = 1'b1;
      end
      @(negedge clk);
    end
    frame_valid = 1'b0;
    chk("t4 pending empty", 32'(frame_ready), 1);
    drain("t4d", d4);
    chk_idle("t4 end");

    // Reset after the 4th transfer with pending full
    e5 = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
    f5 = '{0, 3, 0, 3, 0, 3, 0, 3, 0};
    g5 = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
    frame_data  = pack(e5);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_data = pack(f5);
    show("t5e", e5, 0);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("t5 pending full", 32'(frame_ready), 0);
    for (int k = 1; k < 4; k++) begin
      show("t5e", e5, k);
      @(negedge clk);
    end
    show("t5e", e5, 4);
    chk("t5 busy before rst", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("t5 rst");
    chk("t5 rst data", 32'(pix_data), 0);
    chk("t5 rst row", 32'(pix_row), 0);
    chk("t5 rst col", 32'(pix_col), 0);
    chk("t5 rst last", 32'(pix_last), 0);
    frame_data  = pack(g5);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    drain("t5g", g5);
    chk_idle("t5 end");

    // Pending full under stall: third frame J held off until frame_ready returns
    h6 = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    i6 = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
    j6 = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
    pix_ready   = 1'b0;
    frame_data  = pack(h6);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_data = pack(i6);
    @(negedge clk);
    frame_data = pack(j6);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("t6 stall%0d ready", s), 32'(frame_ready), 0);
      show("t6h", h6, 0);
      @(negedge clk);
    end
    pix_ready = 1'b1;
    cnt    = 0;
    sent_j = 1'b0;
    for (int cyc = 0; cyc < 60 && cnt < 27; cyc++) begin
      if (sent_j) frame_valid = 1'b0;
      if (frame_valid && frame_ready) sent_j = 1'b1;
      if (cnt < 9) begin
        chk($sformatf("t6.%0d ready", cnt), 32'(frame_ready), 0);
        cur = h6;
      end else if (cnt < 18) begin
        cur = i6;
      end else begin
        cur = j6;
      end
      show($sformatf("t6.%0d", cnt), cur, cnt % 9);
      cnt++;
      @(negedge clk);
    end
    chk("t6 transfers", 32'(cnt), 27);
    chk("t6 J accepted", 32'(sent_j), 1);
    chk_idle("t6 end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
